cnn_scan_ctrl: RTL and testbench
================================

# cnn_scan_ctrl

Parametrised frame-scan controller for the CNN input path, the successor to the single-channel timing controller. It generates vsync/hsync/data phases and a raster of (row, col, channel) coordinates over a zero-padded frame. It also provides:
- per-beat stall (backpressure),
- channel-interleaved beats,
- a KxK convolution-window valid flag with programmable stride,
- continuous multi-frame operation and abort.

It sits between the register block (`q_*` config) and the line buffer / conv engine.

## Interface
Parameters:
- `W_SIZE`, 12: width of width/height/row/col.
- `W_DELAY`, 12: width of sync delay counters.
- `W_CH`, 4: width of channel count/index.
- `W_FRAME_SIZE`, `2*W_SIZE+W_CH`: width of beat counter.
- `K_SIZE`, 3: conv kernel size (1..7).

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `q_width`  in  `W_SIZE`  active pixels per line.
- `q_height`  in  `W_SIZE`  active lines per frame.
- `q_pad`  in  2  zero-pad border in pixels (0..3).
- `q_num_ch`  in  `W_CH`  channel beats per pixel position (1..15).
- `q_stride`  in  2  window stride minus 1 (stride 1..4).
- `q_vsync_delay`  in  `W_DELAY`  vsync length minus 1.
- `q_hsync_delay`  in  `W_DELAY`  hsync length minus 1.
- `q_continuous`  in  1  restart at frame end instead of idling.
- `q_start`  in  1  start pulse.
- `q_stop`  in  1  abort request.
- `i_stall`  in  1  downstream not ready; freezes DATA progress.
- `o_ctrl_vsync_run`, `o_ctrl_hsync_run`, `o_ctrl_data_run`  out  1 each  state decodes.
- `o_ctrl_vsync_cnt`, `o_ctrl_hsync_cnt`  out  `W_DELAY`  sync counters.
- `o_data_valid`  out  1  beat presented this cycle (`data_run & !i_stall`).
- `o_row`, `o_col`  out  `W_SIZE`  padded coordinates.
- `o_ch`  out  `W_CH`  channel index of current beat.
- `o_pad`  out  1  current position is in the pad border.
- `o_win_valid`  out  1  current position completes a strided KxK window.
- `o_data_count`  out  `W_FRAME_SIZE`  valid beats issued this frame.
- `o_end_frame`  out  1  last beat of frame accepted this cycle.
- `o_done`  out  1  one-cycle pulse, cycle after `o_end_frame`.
- `o_busy`  out  1  state ≠ IDLE.
- `o_frame_cnt`  out  16  completed frames since reset, wraps at 2^16.
- `o_cfg_err`  out  1  one-cycle pulse: start rejected.

## Operation
- States: IDLE, VSYNC, HSYNC, DATA. All outputs reset to 0; state resets to IDLE.
- Config capture:
  - On an accepted `q_start` in IDLE, all `q_*` config is latched into shadow registers.
  - On each `q_continuous` restart, config is latched again.
  - Config changes mid-frame have no effect.
- Start rejection: if `q_width`, `q_height` or `q_num_ch` is 0, `q_start` is rejected. State stays IDLE and `o_cfg_err` pulses next cycle.
- Ignored starts: `q_start` outside IDLE is ignored.
- Padded geometry: PW = width + 2·pad, PH = height + 2·pad, computed at `W_SIZE`+1 bits. Software guarantees PW and PH ≤ 2^`W_SIZE`−1.
- IDLE → VSYNC on an accepted start.
- VSYNC → HSYNC when `vsync_cnt` == `vsync_delay`.
- HSYNC → DATA when `hsync_cnt` == `hsync_delay`. An HSYNC phase precedes every line, including the first.
- DATA:
  - Each valid beat advances ch; ch wraps at num_ch−1 and advances col.
  - col wraps at PW−1 and advances row; the state then goes to HSYNC.
  - The last beat (row PH−1, col PW−1, ch num_ch−1) asserts `o_end_frame`.
  - After the last beat, next state is VSYNC if `q_continuous` is 1, else IDLE.
  - row, col, ch and `data_count` clear to 0.
- Sync counters count up while in their state and are 0 otherwise.
- `i_stall` high in DATA holds row, col, ch, `data_count` and state. `o_data_run` stays 1 and `o_data_valid` is 0. `i_stall` is ignored in other states.
- `o_pad` = row < pad | row ≥ PH−pad | col < pad | col ≥ PW−pad.
- `o_win_valid` = row ≥ K−1 & col ≥ K−1 & (row−(K−1)) mod stride == 0 & (col−(K−1)) mod stride == 0.
  - It is constant across all channel beats of a position.
  - It is implemented with per-line and per-frame phase counters, without dividers.
- Abort: `q_stop` high in any non-IDLE state → IDLE next cycle. All counters clear. No `o_end_frame`, no `o_done`, and `o_frame_cnt` is unchanged. Stop takes priority over `end_frame` in the same cycle.
- `o_frame_cnt` increments with `o_done`.

## Timing
- Start latency: `q_start` sampled at edge N → VSYNC from N+1. First data beat at N+1+(vd+1)+(hd+1) with no stall.
- Line period: (hd+1) + PW·num_ch cycles plus stall cycles.
- Output timing: `o_end_frame`, `o_data_valid`, `o_pad`, `o_win_valid` and `o_ch`/`o_row`/`o_col` are combinational from registered state. They are valid in the same cycle as the beat.
- `o_done`, `o_cfg_err` and `o_frame_cnt` are registered, 1 cycle after their cause.
- Continuous mode: VSYNC begins the cycle after `o_end_frame`, with no IDLE cycle and `o_busy` held high.
- Reset is asynchronous at any point: all state returns to reset values immediately.

## Test plan
- Basic frame: width 4, height 3, pad 1, num_ch 2, K 3, stride 1, vd 2, hd 1; start at cycle 0.
  - First valid beat at cycle 6.
  - 60 valid beats, 36 with `o_pad`, 24 with `o_win_valid`.
  - `o_end_frame` at cycle 73, `o_done` at cycle 74, `o_frame_cnt` = 1, `o_busy` low at cycle 74.
- Stride 2: width 5, height 5, pad 0, num_ch 1, stride 2 → `o_win_valid` only at (2,2), (2,4), (4,2), (4,4); 25 beats total.
- Stall: repeat the basic frame with `i_stall` high for 3 cycles on beat 10 and on the last beat.
  - Coordinates hold during the stall.
  - `o_end_frame` moves to cycle 79.
  - Beat count is still 60.
- Continuous: `q_continuous` = 1 for 3 frames → VSYNC directly after each `o_end_frame`, `o_frame_cnt` 1→2→3, `o_busy` never low.
- Abort and config error:
  - `q_stop` mid-line 2 → IDLE next cycle, `o_frame_cnt` unchanged, no `o_done`.
  - `q_start` with `q_num_ch` = 0 → `o_cfg_err` pulse, stays IDLE.
  - `rstn` low mid-DATA → all outputs 0 immediately.

Source files
------------

// File: rtl/cnn_scan_ctrl.sv
// Frame-scan controller for the CNN input path: sync phases, padded raster of
// (row, col, channel) beats, strided KxK window flag, stall, continuous and abort.
module cnn_scan_ctrl #(
  parameter int W_SIZE       = 12,
  parameter int W_DELAY      = 12,
  parameter int W_CH         = 4,
  parameter int W_FRAME_SIZE = 2*W_SIZE+W_CH,
  parameter int K_SIZE       = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [1:0]              q_pad,
  input  logic [W_CH-1:0]         q_num_ch,
  input  logic [1:0]              q_stride,
  input  logic [W_DELAY-1:0]      q_vsync_delay,
  input  logic [W_DELAY-1:0]      q_hsync_delay,
  input  logic                    q_continuous,
  input  logic                    q_start,
  input  logic                    q_stop,
  input  logic                    i_stall,
  output logic                    o_ctrl_vsync_run,
  output logic                    o_ctrl_hsync_run,
  output logic                    o_ctrl_data_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic                    o_data_valid,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CH-1:0]         o_ch,
  output logic                    o_pad,
  output logic                    o_win_valid,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame,
  output logic                    o_done,
  output logic                    o_busy,
  output logic [15:0]             o_frame_cnt,
  output logic                    o_cfg_err
);

  // state  | meaning
  // IDLE   | waiting for an accepted start
  // VSYNC  | frame sync phase, vsync_cnt counts up to vd
  // HSYNC  | line sync phase before every line, hsync_cnt counts up to hd
  // DATA   | issuing (row, col, ch) beats of one padded line
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VSYNC = 2'd1;
  localparam logic [1:0] S_HSYNC = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam int W_P = W_SIZE + 1;
  localparam logic [W_SIZE-1:0] K_M1 = W_SIZE'(K_SIZE - 1);

  logic [1:0]              state;
  logic [W_DELAY-1:0]      vsync_cnt, hsync_cnt;
  logic [W_SIZE-1:0]       row, col;
  logic [W_CH-1:0]         ch;
  logic [W_FRAME_SIZE-1:0] data_count;
  logic [1:0]              row_ph, col_ph;
  logic                    done, cfg_err;
  logic [15:0]             frame_cnt;

  logic [W_P-1:0]          pw, ph;
  logic [1:0]              pad_s, stride_m1;
  logic [W_CH-1:0]         num_ch;
  logic [W_DELAY-1:0]      vd, hd;

  logic cfg_ok, data_run, beat, last_ch, last_col, last_row, end_frame, load;
  logic [W_P-1:0] row_x, col_x, pad_x;
  logic [1:0] row_ph_nxt, col_ph_nxt;

  assign cfg_ok    = (q_width != '0) && (q_height != '0) && (q_num_ch != '0);
  assign data_run  = (state == S_DATA);
  assign beat      = data_run && !i_stall;
  assign last_ch   = (ch == num_ch - W_CH'(1));
  assign row_x     = {1'b0, row};
  assign col_x     = {1'b0, col};
  assign pad_x     = W_P'(pad_s);
  assign last_col  = (col_x == pw - W_P'(1));
  assign last_row  = (row_x == ph - W_P'(1));
  assign end_frame = beat && last_ch && last_col && last_row && !q_stop;
  assign load      = (state == S_IDLE && q_start && cfg_ok) ||
                     (end_frame && q_continuous && cfg_ok);

  // Phases track (pos-(K-1)) mod stride; they sit at 0 until the first full window.
  assign col_ph_nxt = (col < K_M1) ? 2'd0 : (col_ph == stride_m1) ? 2'd0 : col_ph + 2'd1;
  assign row_ph_nxt = (row < K_M1) ? 2'd0 : (row_ph == stride_m1) ? 2'd0 : row_ph + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pw        <= '0;
      ph        <= '0;
      pad_s     <= '0;
      stride_m1 <= '0;
      num_ch    <= '0;
      vd        <= '0;
      hd        <= '0;
    end else if (load) begin
      pw        <= W_P'(q_width) + W_P'({q_pad, 1'b0});
      ph        <= W_P'(q_height) + W_P'({q_pad, 1'b0});
      pad_s     <= q_pad;
      stride_m1 <= q_stride;
      num_ch    <= q_num_ch;
      vd        <= q_vsync_delay;
      hd        <= q_hsync_delay;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      vsync_cnt  <= '0;
      hsync_cnt  <= '0;
      row        <= '0;
      col        <= '0;
      ch         <= '0;
      data_count <= '0;
      row_ph     <= '0;
      col_ph     <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state != S_IDLE && q_stop) begin
        state      <= S_IDLE;
        vsync_cnt  <= '0;
        hsync_cnt  <= '0;
        row        <= '0;
        col        <= '0;
        ch         <= '0;
        data_count <= '0;
        row_ph     <= '0;
        col_ph     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (q_start) begin
              if (cfg_ok) state <= S_VSYNC;
              else        cfg_err <= 1'b1;
            end
          end
          S_VSYNC: begin
            if (vsync_cnt == vd) begin
              vsync_cnt <= '0;
              state     <= S_HSYNC;
            end else begin
              vsync_cnt <= vsync_cnt + W_DELAY'(1);
            end
          end
          S_HSYNC: begin
            if (hsync_cnt == hd) begin
              hsync_cnt <= '0;
              state     <= S_DATA;
            end else begin
              hsync_cnt <= hsync_cnt + W_DELAY'(1);
            end
          end
          S_DATA: begin
            if (beat) begin
              data_count <= data_count + W_FRAME_SIZE'(1);
              if (!last_ch) begin
                ch <= ch + W_CH'(1);
              end else begin
                ch <= '0;
                if (!last_col) begin
                  col    <= col + W_SIZE'(1);
                  col_ph <= col_ph_nxt;
                end else begin
                  col    <= '0;
                  col_ph <= '0;
                  if (!last_row) begin
                    row    <= row + W_SIZE'(1);
                    row_ph <= row_ph_nxt;
                    state  <= S_HSYNC;
                  end else begin
                    row        <= '0;
                    row_ph     <= '0;
                    data_count <= '0;
                    done       <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    // A continuous restart with bad live config falls back to IDLE.
                    if (q_continuous && cfg_ok) begin
                      state <= S_VSYNC;
                    end else begin
                      state   <= S_IDLE;
                      cfg_err <= q_continuous;
                    end
                  end
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ctrl_vsync_run = (state == S_VSYNC);
  assign o_ctrl_hsync_run = (state == S_HSYNC);
  assign o_ctrl_data_run  = data_run;
  assign o_ctrl_vsync_cnt = vsync_cnt;
  assign o_ctrl_hsync_cnt = hsync_cnt;
  assign o_data_valid     = beat;
  assign o_row            = row;
  assign o_col            = col;
  assign o_ch             = ch;
  assign o_pad            = data_run && ((row_x < pad_x) || (row_x >= ph - pad_x) ||
                                         (col_x < pad_x) || (col_x >= pw - pad_x));
  assign o_win_valid      = data_run && (row >= K_M1) && (col >= K_M1) &&
                            (row_ph == 2'd0) && (col_ph == 2'd0);
  assign o_data_count     = data_count;
  assign o_end_frame      = end_frame;
  assign o_done           = done;
  assign o_busy           = (state != S_IDLE);
  assign o_frame_cnt      = frame_cnt;
  assign o_cfg_err        = cfg_err;

endmodule

// File: tb/tb_cnn_scan_ctrl.sv
// Randomised bench for cnn_scan_ctrl: every beat is compared against a raster
// model derived from beat index arithmetic, plus directed timing scenarios.
module tb_cnn_scan_ctrl;
  localparam int W_SIZE = 12, W_DELAY = 12, W_CH = 4, W_FRAME_SIZE = 28, K = 3;

  logic clk = 1'b0, rstn = 1'b0;
  logic [W_SIZE-1:0] q_width = '0, q_height = '0;
  logic [1:0] q_pad = '0, q_stride = '0;
  logic [W_CH-1:0] q_num_ch = '0;
  logic [W_DELAY-1:0] q_vsync_delay = '0, q_hsync_delay = '0;
  logic q_continuous = 1'b0, q_start = 1'b0, q_stop = 1'b0, i_stall = 1'b0;
  logic o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
  logic [W_DELAY-1:0] o_ctrl_vsync_cnt, o_ctrl_hsync_cnt;
  logic o_data_valid, o_pad, o_win_valid, o_end_frame, o_done, o_busy, o_cfg_err;
  logic [W_SIZE-1:0] o_row, o_col;
  logic [W_CH-1:0] o_ch;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic [15:0] o_frame_cnt;

  cnn_scan_ctrl dut (
    .clk(clk), .rstn(rstn), .q_width(q_width), .q_height(q_height), .q_pad(q_pad),
    .q_num_ch(q_num_ch), .q_stride(q_stride), .q_vsync_delay(q_vsync_delay),
    .q_hsync_delay(q_hsync_delay), .q_continuous(q_continuous), .q_start(q_start),
    .q_stop(q_stop), .i_stall(i_stall), .o_ctrl_vsync_run(o_ctrl_vsync_run),
    .o_ctrl_hsync_run(o_ctrl_hsync_run), .o_ctrl_data_run(o_ctrl_data_run),
    .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
    .o_data_valid(o_data_valid), .o_row(o_row), .o_col(o_col), .o_ch(o_ch), .o_pad(o_pad),
    .o_win_valid(o_win_valid), .o_data_count(o_data_count), .o_end_frame(o_end_frame),
    .o_done(o_done), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, exp_fc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int w, h, p, nch, str, vd, hd);
    q_width       = W_SIZE'(w);
    q_height      = W_SIZE'(h);
    q_pad         = 2'(p);
    q_num_ch      = W_CH'(nch);
    q_stride      = 2'(str - 1);
    q_vsync_delay = W_DELAY'(vd);
    q_hsync_delay = W_DELAY'(hd);
  endtask

  // mode: 0 no stall, 1 three stall cycles on beat 10 and the last beat, 2 random stall
  task automatic run_frames(input int w, h, p, nch, str, vd, hd, nfr, mode,
                            output int beats, output int pads, output int wins, output int end_rel);
    int pw, ph, fb, rel, ref_c, idx, frame, stalls, held, last_end, t0;
    int er, ec, ech, ep, ewn;
    bit st, first_seen, fin, evs;
    pw = w + 2*p; ph = h + 2*p; fb = pw*ph*nch;
    beats = 0; pads = 0; wins = 0; end_rel = -1;
    @(negedge clk);
    set_cfg(w, h, p, nch, str, vd, hd);
    q_continuous = (nfr > 1);
    q_stop = 1'b0; i_stall = 1'b0; q_start = 1'b1;
    t0 = cyc; ref_c = 0; idx = 0; frame = 0; stalls = 0; held = 0;
    last_end = -10; first_seen = 0; fin = 0;
    for (int n = 0; n < 20000 && !fin; n++) begin
      @(negedge clk);
      q_start = 1'b0;
      rel = cyc - t0;
      if (rel == last_end + 1) q_continuous = (frame < nfr - 1);
      st = 0;
      if (o_ctrl_data_run) begin
        if (mode == 1 && (idx == 10 || idx == fb - 1) && held < 3) begin st = 1; held++; end
        else if (mode == 2) st = ($urandom_range(0, 3) == 0);
      end
      i_stall = st;
      #1;
      if (rel == last_end + 1) begin
        check_eq("done_pulse", o_done, 1);
        check_eq("frame_cnt", o_frame_cnt, exp_fc);
        if (frame == nfr) begin
          check_eq("busy_after", o_busy, 0);
          fin = 1;
        end
      end else check_eq("done_quiet", o_done, 0);
      if (frame < nfr) check_eq("busy", o_busy, 1);
      evs = (frame < nfr) && rel > ref_c && rel <= ref_c + vd + 1;
      check_eq("vsync_run", o_ctrl_vsync_run, evs);
      check_eq("vsync_cnt", o_ctrl_vsync_cnt, evs ? rel - ref_c - 1 : 0);
      if (o_ctrl_data_run && !first_seen) begin
        first_seen = 1;
        check_eq("first_data", rel - ref_c, vd + hd + 3);
      end
      check_eq("valid", o_data_valid, o_ctrl_data_run && !st);
      er = idx / (nch*pw); ec = (idx / nch) % pw; ech = idx % nch;
      if (o_ctrl_data_run) begin
        check_eq("row", o_row, er);
        check_eq("col", o_col, ec);
        check_eq("ch", o_ch, ech);
        check_eq("data_count", o_data_count, idx);
        if (st) stalls++;
      end
      if (o_data_valid) begin
        ep  = (er < p || er >= ph - p || ec < p || ec >= pw - p) ? 1 : 0;
        ewn = (er >= K-1 && ec >= K-1 && (er-(K-1)) % str == 0 && (ec-(K-1)) % str == 0) ? 1 : 0;
        check_eq("pad", o_pad, ep);
        check_eq("win", o_win_valid, ewn);
        check_eq("end_frame", o_end_frame, idx == fb - 1);
        beats++; pads += ep; wins += ewn;
        idx++; held = 0;
        if (idx == fb) begin
          check_eq("end_cycle", rel - ref_c, 1 + (vd+1) + ph*(hd+1) + fb - 1 + stalls);
          last_end = rel; ref_c = rel; end_rel = rel;
          frame++; idx = 0; stalls = 0; first_seen = 0; exp_fc++;
        end
      end else check_eq("end_frame_idle", o_end_frame, 0);
    end
    if (!fin) check_eq("timeout", 0, 1);
    i_stall = 1'b0;
    q_continuous = 1'b0;
  endtask

  int b, pd, wn, e;
  int rw, rh, rp, rn, rs, rv, rhd, rf, rm;
  bit found;

  initial begin
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_data_run", o_ctrl_data_run, 0);
    check_eq("rst_vsync_run", o_ctrl_vsync_run, 0);
    check_eq("rst_pad", o_pad, 0);
    check_eq("rst_win", o_win_valid, 0);
    check_eq("rst_frame_cnt", o_frame_cnt, 0);
    check_eq("rst_end", o_end_frame, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    run_frames(4, 3, 1, 2, 1, 2, 1, 1, 0, b, pd, wn, e);
    check_eq("basic_beats", b, 60);
    check_eq("basic_pads", pd, 36);
    check_eq("basic_wins", wn, 24);
    check_eq("basic_end", e, 73);

    run_frames(5, 5, 0, 1, 2, 1, 0, 1, 0, b, pd, wn, e);
    check_eq("stride_beats", b, 25);
    check_eq("stride_wins", wn, 4);

    run_frames(4, 3, 1, 2, 1, 2, 1, 1, 1, b, pd, wn, e);
    check_eq("stall_beats", b, 60);
    check_eq("stall_end", e, 79);

    run_frames(4, 3, 1, 2, 1, 2, 1, 3, 0, b, pd, wn, e);
    check_eq("cont_beats", b, 180);
    check_eq("cont_end", e, 219);

    for (int t = 0; t < 6; t++) begin
      rw = $urandom_range(1, 6); rh = $urandom_range(1, 5); rp = $urandom_range(0, 3);
      rn = $urandom_range(1, 3); rs = $urandom_range(1, 4); rv = $urandom_range(0, 3);
      rhd = $urandom_range(0, 3); rf = $urandom_range(1, 2); rm = 2 * $urandom_range(0, 1);
      run_frames(rw, rh, rp, rn, rs, rv, rhd, rf, rm, b, pd, wn, e);
      check_eq("rand_beats", b, rf*(rw+2*rp)*(rh+2*rp)*rn);
    end

    // abort mid-line 2
    @(negedge clk);
    set_cfg(4, 3, 1, 2, 1, 2, 1);
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (o_ctrl_data_run && o_row == 2 && o_col == 3) found = 1;
    end
    check_eq("abort_reach", found, 1);
    q_stop = 1'b1;
    #1;
    check_eq("abort_no_end", o_end_frame, 0);
    @(negedge clk);
    q_stop = 1'b0;
    #1;
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_data_run", o_ctrl_data_run, 0);
    check_eq("abort_row", o_row, 0);
    check_eq("abort_col", o_col, 0);
    check_eq("abort_count", o_data_count, 0);
    check_eq("abort_fc", o_frame_cnt, exp_fc);
    for (int n = 0; n < 3; n++) begin
      check_eq("abort_no_done", o_done, 0);
      @(negedge clk);
      #1;
    end

    // start rejected on zero channels
    q_num_ch = '0;
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    #1;
    check_eq("cfg_err_pulse", o_cfg_err, 1);
    check_eq("cfg_err_idle", o_busy, 0);
    @(negedge clk);
    #1;
    check_eq("cfg_err_clear", o_cfg_err, 0);
    check_eq("cfg_err_idle2", o_busy, 0);

    // async reset mid-DATA
    q_num_ch = W_CH'(2);
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (o_ctrl_data_run) found = 1;
    end
    check_eq("rst_reach", found, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("arst_busy", o_busy, 0);
    check_eq("arst_data_run", o_ctrl_data_run, 0);
    check_eq("arst_valid", o_data_valid, 0);
    check_eq("arst_col", o_col, 0);
    check_eq("arst_count", o_data_count, 0);
    check_eq("arst_fc", o_frame_cnt, 0);
    exp_fc = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
